// File: rtl/dense_layer1_mac_if.sv
// rtl/dense_layer1_mac_if.sv - control, operand and result bundle for the layer-1 MAC engine
interface dense_layer1_mac_if #(
  parameter int IN_SIZE  = 1152,
  parameter int OUT_SIZE = 8,
  parameter int W        = 8
);
  logic                         start;
  logic                         weights_valid;
  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in;
  logic [IN_SIZE*W-1:0]          act_in;
  logic [OUT_SIZE*W-1:0]         data_out;
  logic                         busy;
  logic                         done;

  modport master (
    output start, weights_valid, weights_in, act_in,
    input  data_out, busy, done
  );

  modport slave (
    input  start, weights_valid, weights_in, act_in,
    output data_out, busy, done
  );
endinterface

// File: rtl/dense_layer1_mac.sv
// rtl/dense_layer1_mac.sv - sequential fully-connected layer, one signed MAC per cycle
module dense_layer1_mac #(
  parameter int IN_SIZE   = 1152,
  parameter int OUT_SIZE  = 8,
  parameter int W         = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_SHIFT = 0,
  parameter int RELU      = 1
) (
  input logic              clk,
  input logic              rst_n,
  dense_layer1_mac_if.slave bus
);

  localparam int IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OUT_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int WB_W  = $clog2(IN_SIZE * OUT_SIZE * W);
  localparam int AB_W  = $clog2(IN_SIZE * W);
  localparam int DB_W  = $clog2(OUT_SIZE * W);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [IDX_W-1:0]         r_in_idx;
  logic [OUT_W-1:0]         r_out_idx;
  logic [OUT_SIZE*W-1:0]    r_data_out;

  logic                     w_in_last;
  logic                     w_out_last;
  logic                     w_accept;
  logic [WB_W-1:0]          w_wbit;
  logic [AB_W-1:0]          w_abit;
  logic [DB_W-1:0]          w_dbit;
  logic [W-1:0]             w_wt;
  logic [W-1:0]             w_act;
  logic signed [2*W-1:0]    w_prod;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [W-1:0]             w_sat;

  assign w_in_last  = (r_in_idx == IDX_W'(IN_SIZE - 1));
  assign w_out_last = (r_out_idx == OUT_W'(OUT_SIZE - 1));
  assign w_accept   = bus.start && bus.weights_valid;

  // Operand bit offsets; weight slot is neuron-major over the flattened bus
  assign w_wbit = WB_W'(r_out_idx) * WB_W'(IN_SIZE * W) + WB_W'(r_in_idx) * WB_W'(W);
  assign w_abit = AB_W'(r_in_idx) * AB_W'(W);
  assign w_dbit = DB_W'(r_out_idx) * DB_W'(W);

  assign w_wt   = bus.weights_in[w_wbit +: W];
  assign w_act  = bus.act_in[w_abit +: W];
  assign w_prod = $signed({{W{w_wt[W-1]}}, w_wt}) * $signed({{W{w_act[W-1]}}, w_act});

  // Arithmetic shift floors toward minus infinity, matching the intended requantisation
  assign w_shifted = r_acc >>> OUT_SHIFT;

  // Optional ReLU followed by clamp into the signed W-bit output range
  always_comb begin
    w_sat = w_shifted[W-1:0];
    if ((RELU != 0) && (w_shifted < 0)) begin
      w_sat = '0;
    end else if (w_shifted > SAT_MAX) begin
      w_sat = {1'b0, {(W-1){1'b1}}};
    end else if (w_shifted < SAT_MIN) begin
      w_sat = {1'b1, {(W-1){1'b0}}};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: IN_SIZE MAC cycles then one WRITE per neuron, then a single DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
      S_MAC:   if (w_in_last) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_out_last ? S_DONE : S_MAC;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, indices and result slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_in_idx   <= '0;
      r_out_idx  <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc     <= '0;
            r_in_idx  <= '0;
            r_out_idx <= '0;
          end
        end
        S_MAC: begin
          r_acc    <= r_acc + {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
          r_in_idx <= w_in_last ? '0 : r_in_idx + IDX_W'(1);
        end
        S_WRITE: begin
          r_data_out[w_dbit +: W] <= w_sat;
          r_acc                   <= '0;
          if (!w_out_last) begin
            r_out_idx <= r_out_idx + OUT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_dense_layer1_mac.sv
// tb/tb_dense_layer1_mac.sv - self-checking bench for dense_layer1_mac
module tb_dense_layer1_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam int IA = 4;
  localparam int OA = 2;
  localparam int LA = OA * (IA + 1);

  dense_layer1_mac_if #(.IN_SIZE(IA), .OUT_SIZE(OA), .W(8)) ifa ();
  dense_layer1_mac_if #(.IN_SIZE(IA), .OUT_SIZE(OA), .W(8)) ifb ();
  dense_layer1_mac_if #(.IN_SIZE(IA), .OUT_SIZE(OA), .W(8)) ifc ();
  dense_layer1_mac_if #(.IN_SIZE(1152), .OUT_SIZE(8), .W(8)) ifd ();

  dense_layer1_mac #(.IN_SIZE(IA), .OUT_SIZE(OA), .W(8), .ACC_W(32), .OUT_SHIFT(0), .RELU(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  dense_layer1_mac #(.IN_SIZE(IA), .OUT_SIZE(OA), .W(8), .ACC_W(32), .OUT_SHIFT(2), .RELU(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  dense_layer1_mac #(.IN_SIZE(IA), .OUT_SIZE(OA), .W(8), .ACC_W(32), .OUT_SHIFT(0), .RELU(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  dense_layer1_mac #(.IN_SIZE(1152), .OUT_SIZE(8), .W(8), .ACC_W(32), .OUT_SHIFT(4), .RELU(1))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Requantisation rule: floor division by 2^shift, optional ReLU, clamp to int8
  function automatic int scale_sat(input longint sum, input int shift, input bit relu);
    longint d;
    longint q;
    d = longint'(1) << shift;
    if (sum >= 0) q = sum / d;
    else          q = -((-sum + d - 1) / d);
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  // Vectors currently on the small buses (shared by dut_a/b/c)
  int v_act[IA];
  int v_w[IA*OA];

  function automatic longint dot(input int o);
    longint s = 0;
    for (int i = 0; i < IA; i++) s += longint'(v_w[o*IA+i]) * longint'(v_act[i]);
    return s;
  endfunction

  // Timing/result model of dut_a: run of LA edges after acceptance, slot o lands at (o+1)*(IA+1)
  int          t_a = -1;
  logic [15:0] exp_a = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_a   <= -1;
      exp_a <= '0;
    end else if (t_a < 0) begin
      if (ifa.start && ifa.weights_valid) t_a <= 0;
    end else if (t_a == LA) begin
      t_a <= -1;
    end else begin
      t_a <= t_a + 1;
      if ((t_a + 1) % (IA + 1) == 0)
        exp_a[((t_a + 1) / (IA + 1) - 1) * 8 +: 8] <= 8'(scale_sat(dot((t_a + 1) / (IA + 1) - 1), 0, 1'b1));
    end
  end

  // Per-cycle comparison of dut_a against the model
  always @(negedge clk) begin
    chk("a_busy", longint'(ifa.busy), longint'(t_a >= 0));
    chk("a_done", longint'(ifa.done), longint'(t_a == LA));
    chk("a_data", longint'(ifa.data_out), longint'(exp_a));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_small(input int act[IA], input int w[IA*OA]);
    for (int i = 0; i < IA; i++) begin
      v_act[i] = act[i];
      ifa.act_in[i*8 +: 8] = 8'(act[i]);
      ifb.act_in[i*8 +: 8] = 8'(act[i]);
      ifc.act_in[i*8 +: 8] = 8'(act[i]);
    end
    for (int k = 0; k < IA*OA; k++) begin
      v_w[k] = w[k];
      ifa.weights_in[k*8 +: 8] = 8'(w[k]);
      ifb.weights_in[k*8 +: 8] = 8'(w[k]);
      ifc.weights_in[k*8 +: 8] = 8'(w[k]);
    end
  endtask

  function automatic logic done_of(input int which);
    case (which)
      1:       return ifb.done;
      2:       return ifc.done;
      3:       return ifd.done;
      default: return ifa.done;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      1:       ifb.start = v;
      2:       ifc.start = v;
      3:       ifd.start = v;
      default: ifa.start = v;
    endcase
  endtask

  // Counts edges after the accepting edge until done is seen; timeout counts as a failure
  task automatic wait_done(input int which, input int lat0, input int budget, output int lat);
    lat = lat0;
    while (done_of(which) !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    if (done_of(which) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout dut=%0d actual=no_done required=done_within_%0d", which, budget);
    end
  endtask

  task automatic run(input int which, input int budget, output int lat);
    set_start(which, 1'b1);
    tick();
    set_start(which, 1'b0);
    wait_done(which, 0, budget, lat);
  endtask

  int lat;

  initial begin
    ifa.start = 0; ifb.start = 0; ifc.start = 0; ifd.start = 0;
    ifa.weights_valid = 0; ifb.weights_valid = 1; ifc.weights_valid = 1; ifd.weights_valid = 1;
    ifa.weights_in = '0; ifb.weights_in = '0; ifc.weights_in = '0; ifd.weights_in = '0;
    ifa.act_in = '0; ifb.act_in = '0; ifc.act_in = '0; ifd.act_in = '0;
    for (int i = 0; i < IA; i++) v_act[i] = 0;
    for (int k = 0; k < IA*OA; k++) v_w[k] = 0;
    tick(); tick();
    chk("rst_busy", longint'(ifa.busy), 0);
    chk("rst_done", longint'(ifa.done), 0);
    chk("rst_data", longint'(ifa.data_out), 0);
    rst_n = 1'b1;
    tick();

    // Basic: ReLU clips the negative neuron
    load_small('{1, 2, 3, 4}, '{1, 1, 1, 1, -1, -1, -1, -1});
    ifa.weights_valid = 1'b1;
    run(0, 40, lat);
    chk("basic_latency", lat, 10);
    chk("basic_slot0", longint'($signed(ifa.data_out[7:0])), 10);
    chk("basic_slot1", longint'($signed(ifa.data_out[15:8])), 0);
    tick();
    chk("basic_idle", longint'(ifa.busy), 0);

    // Gating: no acceptance without weights_valid, and start while busy ignored
    ifa.weights_valid = 1'b0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick();
    chk("gate_busy", longint'(ifa.busy), 0);
    ifa.weights_valid = 1'b1;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick(); tick();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    wait_done(0, 3, 40, lat);
    chk("gate_latency", lat, 10);
    tick();
    chk("gate_idle", longint'(ifa.busy), 0);

    // Reset mid-run after the first slot of a new run has been written
    load_small('{5, -6, 7, -8}, '{1, -1, 1, -1, 3, 0, 0, 0});
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_slot0_new", longint'($signed(ifa.data_out[7:0])), 26);
    chk("mid_slot1_old", longint'($signed(ifa.data_out[15:8])), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", longint'(ifa.data_out), 0);
    chk("mid_rst_busy", longint'(ifa.busy), 0);
    chk("mid_rst_done", longint'(ifa.done), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run(0, 40, lat);
    chk("rerun_latency", lat, 10);
    chk("rerun_slot0", longint'($signed(ifa.data_out[7:0])), 26);
    chk("rerun_slot1", longint'($signed(ifa.data_out[15:8])), 15);
    tick();

    // Signed shift on dut_b: floor semantics for negative sums
    load_small('{1, 2, 3, 4}, '{1, 1, 1, 1, -1, -1, -1, -1});
    run(1, 40, lat);
    chk("shift_latency", lat, 10);
    chk("shift_slot0", longint'($signed(ifb.data_out[7:0])), 2);
    chk("shift_slot1", longint'($signed(ifb.data_out[15:8])), -3);
    chk("shift_model0", longint'($signed(ifb.data_out[7:0])), scale_sat(dot(0), 2, 1'b0));
    chk("shift_model1", longint'($signed(ifb.data_out[15:8])), scale_sat(dot(1), 2, 1'b0));
    tick();

    // Saturation on dut_c, both rails
    load_small('{127, 127, 127, 127}, '{127, 127, 127, 127, -128, -128, -128, -128});
    run(2, 40, lat);
    chk("sat_latency", lat, 10);
    chk("sat_slot0", longint'($signed(ifc.data_out[7:0])), 127);
    chk("sat_slot1", longint'($signed(ifc.data_out[15:8])), -128);
    chk("sat_model1", longint'($signed(ifc.data_out[15:8])), scale_sat(dot(1), 0, 1'b0));
    tick();

    // Default sizing smoke test on dut_d
    ifd.act_in     = {1152{8'h01}};
    ifd.weights_in = {9216{8'h01}};
    run(3, 9400, lat);
    chk("full_latency", lat, 9224);
    for (int o = 0; o < 8; o++) begin
      chk($sformatf("full_slot%0d", o), longint'($signed(ifd.data_out[o*8 +: 8])), 72);
    end
    chk("full_model", longint'($signed(ifd.data_out[63:56])), scale_sat(1152, 4, 1'b1));
    tick();
    chk("full_idle", longint'(ifd.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dense_layer1_mac.md
Name: dense_layer1_mac

Overview:
- Fully-connected layer engine directly downstream of the layer-1 weight loader.
- Consumes the loader's flattened weight bus once the loader signals done, plus a flattened activation vector. Computes OUT_SIZE neuron outputs.
- Uses one signed multiply-accumulate per cycle.
- Each accumulated sum is scaled by an arithmetic right shift, optionally passed through ReLU, and saturated back to W bits.

Parameters:
- IN_SIZE, 1152: inputs per neuron.
- OUT_SIZE, 8: number of neurons.
- W, 8: bit width of activations, weights and outputs; all signed two's complement.
- ACC_W, 32: accumulator width; must be at least 2*W + clog2(IN_SIZE).
- OUT_SHIFT, 0: arithmetic right-shift amount applied to the accumulator before saturation.
- RELU, 1: 1 applies ReLU after the shift; 0 bypasses it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to compute the layer.
- weights_valid  input  1  connected to the weight loader's done; weight bus contents are valid.
- weights_in  input  IN_SIZE*OUT_SIZE*W  flattened weights; weight for neuron o, input i is at slot k = o*IN_SIZE + i, bits [k*W +: W].
- act_in  input  IN_SIZE*W  flattened activations; input i is at [i*W +: W].
- data_out  output  OUT_SIZE*W  results; neuron o is at [o*W +: W].
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; data_out=0; done=0; busy=0.
  - acc=0; in_idx=0; out_idx=0.
- States: IDLE, MAC, WRITE, DONE. The state is registered; busy and done decode from it.
- IDLE:
  - Leaves on a clock edge only when start=1 and weights_valid=1.
  - On that edge: acc=0, in_idx=0, out_idx=0, state=MAC.
  - start while weights_valid=0 is ignored; there is no sticky request.
- MAC:
  - Each cycle: acc += sext(weights_in[(out_idx*IN_SIZE+in_idx)*W +: W]) * sext(act_in[in_idx*W +: W]), full signed product.
  - in_idx increments each cycle.
  - On the cycle with in_idx==IN_SIZE-1: in_idx resets to 0 and state goes to WRITE. The state stays in MAC for exactly IN_SIZE cycles.
- WRITE (one cycle):
  - r = acc >>> OUT_SHIFT (floor toward minus infinity).
  - If RELU=1 and r<0, r=0.
  - r is saturated to [-2^(W-1), 2^(W-1)-1].
  - Result written to data_out[out_idx*W +: W]; acc cleared.
  - If out_idx==OUT_SIZE-1, go to DONE; otherwise out_idx+1 and return to MAC.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - data_out holds its values until the next run's WRITE cycles or a reset.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E0 + OUT_SIZE*(IN_SIZE+1).
  - Default parameters: 9224 cycles.
- Contract: weights_in and act_in must be held stable from the accepting edge until done. The block does not latch them.
- start while busy=1 is ignored; a run is never restarted mid-flight.
- start=1 in the DONE cycle is ignored. A new run needs start sampled in IDLE, so back-to-back runs have a one-cycle IDLE gap.
- Reset mid-run: immediate return to IDLE with data_out=0. Partial results are discarded and no done pulse is produced.
- Data_out update order: slots update one at a time in the WRITE cycles. Earlier slots already hold new values while later slots still hold the previous run's values.
- Accumulator: no internal overflow check. Sizing ACC_W correctly is the integrator's responsibility.

Test Plan (IN_SIZE=4, OUT_SIZE=2, W=8, ACC_W=32):
- Basic: OUT_SHIFT=0, RELU=1, act=[1,2,3,4], weights neuron0=[1,1,1,1] and neuron1=[-1,-1,-1,-1]. Expect data_out slot0=10, slot1=0 (ReLU). done high only in the cycle after edge E0+10.
- Signed and shift: OUT_SHIFT=2, RELU=0, same vectors. Expect slot0=2, slot1=-3 (0xFD); -10>>>2 floors to -3.
- Saturation: OUT_SHIFT=0, RELU=0, act all 127; neuron0 weights all 127, neuron1 weights all -128. Expect slot0=127, slot1=-128 (0x80).
- Gating: start pulsed with weights_valid=0 leaves busy=0. Then weights_valid=1 and start; a second start pulse at edge E0+3 is ignored and done still occurs exactly once at E0+10.
- Reset mid-run: after the first run completes, start a second run and drop rst_n at edge E0+6. Expect asynchronous clear to data_out=0, busy=0, no done pulse. A later start recomputes correct results.
- Default sizing smoke test: IN_SIZE=1152, OUT_SIZE=8, act all 1, weights all 1, OUT_SHIFT=4. Expect every slot to be 72 (1152>>4) and done after 9224 cycles.
